// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: function codes, port ids and the
// legal-operation decode used to flag ops the ALU does not implement.
package alu_arbiter_pkg;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // Ten implemented ops: every base-encoded funct3, plus SUB and SRA.
  function automatic logic is_legal_op(input logic [2:0] funct3, input logic [6:0] funct7);
    logic legal;
    legal = 1'b0;
    if (funct7 == F7_BASE) begin
      case (funct3)
        F3_ADD_SUB, F3_SLL, F3_SLT, F3_SLTU,
        F3_XOR, F3_SRL_SRA, F3_OR, F3_AND: legal = 1'b1;
        default:                           legal = 1'b0;
      endcase
    end else if (funct7 == F7_ALT) begin
      legal = (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
    end
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rsp_slot.sv
// One-entry response register with valid/ready handshake and error flag.
// A load in the same cycle as a drain keeps the slot full with the new data.
module alu_rsp_slot #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_rd,
  input  logic            load_err,
  input  logic            rsp_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rd,
  output logic            rsp_err
);

  // Fill on load, empty on consumer handshake; data holds while full and stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_rd    <= load_rd;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op issues per cycle; its result lands in the granted port's response
// slot on the following edge.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic [XLEN-1:0]  req0_rs1,
  input  logic [XLEN-1:0]  req0_rs2,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_rd,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  input  logic [XLEN-1:0]  req1_rs1,
  input  logic [XLEN-1:0]  req1_rs2,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_rd,
  output logic             rsp1_err,
  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  input  logic [XLEN-1:0]  alu_rd,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  port_e last_grant;
  logic  free0, free1;
  logic  elig0, elig1;
  logic  grant0, grant1;
  logic  issue_err;

  // Ready is computed from slot space and the other port only, so a port's
  // ready never loops back through its own valid.
  always_comb begin
    free0      = !rsp0_valid || rsp0_ready;
    free1      = !rsp1_valid || rsp1_ready;
    elig0      = req0_valid && free0;
    elig1      = req1_valid && free1;
    req0_ready = free0 && (!elig1 || (last_grant == PORT1));
    req1_ready = free1 && (!elig0 || (last_grant == PORT0));
    grant0     = req0_valid && req0_ready;
    grant1     = req1_valid && req1_ready;
  end

  // Steer the granted request onto the ALU; idle cycles present zeros.
  always_comb begin
    alu_funct3 = '0;
    alu_funct7 = '0;
    alu_rs1    = '0;
    alu_rs2    = '0;
    if (grant0) begin
      alu_funct3 = req0_funct3;
      alu_funct7 = req0_funct7;
      alu_rs1    = req0_rs1;
      alu_rs2    = req0_rs2;
    end else if (grant1) begin
      alu_funct3 = req1_funct3;
      alu_funct7 = req1_funct7;
      alu_rs1    = req1_rs1;
      alu_rs2    = req1_rs2;
    end
    issue_err = !is_legal_op(alu_funct3, alu_funct7);
  end

  // Round-robin pointer and saturating per-port grant counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= PORT1;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0) begin
        last_grant <= PORT0;
        if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      end else if (grant1) begin
        last_grant <= PORT1;
        if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
    end
  end

  alu_rsp_slot #(.XLEN(XLEN)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant0),
    .load_rd   (alu_rd),
    .load_err  (issue_err),
    .rsp_ready (rsp0_ready),
    .rsp_valid (rsp0_valid),
    .rsp_rd    (rsp0_rd),
    .rsp_err   (rsp0_err)
  );

  alu_rsp_slot #(.XLEN(XLEN)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant1),
    .load_rd   (alu_rd),
    .load_err  (issue_err),
    .rsp_ready (rsp1_ready),
    .rsp_valid (rsp1_valid),
    .rsp_rd    (rsp1_rd),
    .rsp_err   (rsp1_err)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a reference ALU closes the loop on the ALU port, a
// per-port scoreboard queues expected results at request handshake and checks
// them when the response is consumed, and directed steps check arbitration.
module tb_alu_arbiter;

  localparam int XLEN  = 64;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_funct3, req1_funct3;
  logic [6:0]       req0_funct7, req1_funct7;
  logic [XLEN-1:0]  req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [XLEN-1:0]  rsp0_rd, rsp1_rd;
  logic             rsp0_err, rsp1_err;
  logic [2:0]       alu_funct3;
  logic [6:0]       alu_funct7;
  logic [XLEN-1:0]  alu_rs1, alu_rs2, alu_rd;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  int vectors;
  int miscompares;

  logic [64:0]      q0[$];
  logic [64:0]      q1[$];
  logic [CNT_W-1:0] exp_cnt0, exp_cnt1;

  alu_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
    .req0_funct7(req0_funct7), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rd(rsp0_rd), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct3(req1_funct3),
    .req1_funct7(req1_funct7), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rd(rsp1_rd), .rsp1_err(rsp1_err),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_rd(alu_rd), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
  endfunction

  function automatic logic [63:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[5:0];
        3'd2: r = {63'd0, sa < sb};
        3'd3: r = {63'd0, a < b};
        3'd4: r = a ^ b;
        3'd5: r = a >> b[5:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) begin
      r = a - b;
    end else if (f7 == 7'h20 && f3 == 3'd5) begin
      r = sa >>> b[5:0];
    end
    return r;
  endfunction

  // External ALU stand-in; illegal ops produce 0.
  assign alu_rd = ref_alu(alu_funct3, alu_funct7, alu_rs1, alu_rs2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [63:0] a, input logic [63:0] b);
    req0_valid = v; req0_funct3 = f3; req0_funct7 = f7; req0_rs1 = a; req0_rs2 = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [63:0] a, input logic [63:0] b);
    req1_valid = v; req1_funct3 = f3; req1_funct7 = f7; req1_rs1 = a; req1_rs2 = b;
  endtask

  // Advance one clock: scoreboard work at the falling edge, counter checks
  // just after the rising edge. Inputs change at posedge+1.
  task automatic cycle();
    logic [64:0] e;
    @(negedge clk);
    chk("single_grant", {63'd0, (req0_valid && req0_ready) && (req1_valid && req1_ready)}, 64'd0);
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      exp_cnt0 = '0;
      exp_cnt1 = '0;
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        chk("rsp0_expected", {63'd0, q0.size() != 0}, 64'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("rsp0_rd", rsp0_rd, e[63:0]);
          chk("rsp0_err", {63'd0, rsp0_err}, {63'd0, e[64]});
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        chk("rsp1_expected", {63'd0, q1.size() != 0}, 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("rsp1_rd", rsp1_rd, e[63:0]);
          chk("rsp1_err", {63'd0, rsp1_err}, {63'd0, e[64]});
        end
      end
      if (req0_valid && req0_ready) begin
        q0.push_back({!ref_legal(req0_funct3, req0_funct7),
                      ref_alu(req0_funct3, req0_funct7, req0_rs1, req0_rs2)});
        if (exp_cnt0 != '1) exp_cnt0 = exp_cnt0 + 1'b1;
      end
      if (req1_valid && req1_ready) begin
        q1.push_back({!ref_legal(req1_funct3, req1_funct7),
                      ref_alu(req1_funct3, req1_funct7, req1_rs1, req1_rs2)});
        if (exp_cnt1 != '1) exp_cnt1 = exp_cnt1 + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("grant_cnt0", 64'(grant_cnt0), 64'(exp_cnt0));
    chk("grant_cnt1", 64'(grant_cnt1), 64'(exp_cnt1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    rst_n = 1'b0;
    set0(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    set1(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1;
    cycle();
    rst_n = 1'b1;

    // Reset state
    chk("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
    chk("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
    chk("rst_rsp0_rd", rsp0_rd, 64'd0);
    chk("rst_rsp1_err", {63'd0, rsp1_err}, 64'd0);
    chk("rst_cnt0", 64'(grant_cnt0), 64'd0);

    // Single ADD on port 0
    set0(1'b1, 3'd0, 7'd0, 64'd5, 64'd7);
    #2;
    chk("add_req0_ready", {63'd0, req0_ready}, 64'd1);
    chk("add_alu_rs1", alu_rs1, 64'd5);
    cycle();
    set0(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    chk("add_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
    chk("add_rsp0_rd", rsp0_rd, 64'd12);
    chk("add_rsp0_err", {63'd0, rsp0_err}, 64'd0);
    chk("add_cnt0", 64'(grant_cnt0), 64'd1);
    #2;
    chk("idle_alu_rs1", alu_rs1, 64'd0);
    cycle();
    chk("add_drained", {63'd0, rsp0_valid}, 64'd0);

    // Contention from a fresh round-robin pointer: 0,1,0,1
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    set0(1'b1, 3'd0, 7'h20, 64'd10, 64'd3);
    set1(1'b1, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd4);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("cont_req0_ready", {63'd0, req0_ready}, 64'((k % 2) == 0));
      chk("cont_req1_ready", {63'd0, req1_ready}, 64'((k % 2) == 1));
      cycle();
      if (k == 0) chk("cont_rd0", rsp0_rd, 64'd7);
      if (k == 1) chk("cont_rd1", rsp1_rd, 64'hF800_0000_0000_0000);
    end
    set0(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    set1(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    cycle();

    // Back-pressure on port 0
    rsp0_ready = 1'b0;
    set0(1'b1, 3'd0, 7'd0, 64'd1, 64'd1);
    #2;
    chk("bp_first_ready", {63'd0, req0_ready}, 64'd1);
    cycle();
    set0(1'b1, 3'd0, 7'd0, 64'd2, 64'd2);
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("bp_full_ready", {63'd0, req0_ready}, 64'd0);
      cycle();
      chk("bp_rd_stable", rsp0_rd, 64'd2);
      chk("bp_valid_held", {63'd0, rsp0_valid}, 64'd1);
    end
    rsp0_ready = 1'b1;
    #2;
    chk("bp_refill_ready", {63'd0, req0_ready}, 64'd1);
    cycle();
    chk("bp_refill_valid", {63'd0, rsp0_valid}, 64'd1);
    chk("bp_refill_rd", rsp0_rd, 64'd4);
    set0(1'b1, 3'd0, 7'd0, 64'd3, 64'd3);
    cycle();
    chk("bp_third_rd", rsp0_rd, 64'd6);
    set0(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    cycle();

    // Unsupported op: consumed, counted, flagged
    set0(1'b1, 3'd0, 7'd1, 64'd9, 64'd9);
    #2;
    chk("ill_req0_ready", {63'd0, req0_ready}, 64'd1);
    cycle();
    set0(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    chk("ill_err", {63'd0, rsp0_err}, 64'd1);
    chk("ill_rd", rsp0_rd, 64'd0);
    cycle();

    // Reset with a full port-1 slot; port 0 wins first afterwards
    rsp1_ready = 1'b0;
    set1(1'b1, 3'd6, 7'd0, 64'hF0, 64'h0F);
    cycle();
    chk("rm_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    chk("rm_rsp1_rd", rsp1_rd, 64'hFF);
    rst_n = 1'b0;
    cycle();
    chk("rm_rsp1_cleared", {63'd0, rsp1_valid}, 64'd0);
    chk("rm_cnt0_zero", 64'(grant_cnt0), 64'd0);
    chk("rm_cnt1_zero", 64'(grant_cnt1), 64'd0);
    rst_n = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, 3'd4, 7'd0, 64'hAA, 64'h0F);
    #2;
    chk("rm_req0_first", {63'd0, req0_ready}, 64'd1);
    chk("rm_req1_wait", {63'd0, req1_ready}, 64'd0);
    cycle();
    set0(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);

    // Port 1 counter saturates at all-ones
    for (int k = 0; k < 5; k++) begin
      set1(1'b1, 3'd2, 7'd0, 64'(k), 64'd2);
      cycle();
    end
    set1(1'b0, 3'd0, 7'd0, 64'd0, 64'd0);
    chk("sat_cnt1", 64'(grant_cnt1), 64'd3);

    // Drain everything still queued, bounded
    for (int k = 0; k < 8 && (q0.size() != 0 || q1.size() != 0 || rsp0_valid || rsp1_valid); k++)
      cycle();
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
